// File: rtl/crc_stream_if.sv
// Byte-stream handshake carrying frame data (FCS included) into the CRC checker.
interface crc_stream_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/crc_stream_check.sv
// Table-driven streaming CRC frame checker: one byte per cycle, residue compare at frame end.
// Optional runt-length check enabled by defining macro CRC_CHK_LEN_EN.
module crc_stream_check #(
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
    input  logic              clk,
    input  logic              rstn,
    crc_stream_if.slave       s,
    output logic [31:0]       tab_addr,
    input  logic [31:0]       tab_rdata,
    output logic              done,
    output logic              pass,
    output logic [31:0]       crc_out
);

    typedef enum logic [0:0] {StRun, StReport} state_e;

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_out_q, crc_out_d;
    logic        ready;
    logic        accept;
    logic        len_ok;

    assign s.s_ready = ready;
    assign accept    = s.s_valid & ready;
    assign tab_addr  = {24'h0, crc_q[7:0] ^ s.s_data};
    assign crc_out   = crc_out_q;

`ifdef CRC_CHK_LEN_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (state_q == StReport) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Runt: fewer than one payload byte plus the four FCS bytes.
    assign len_ok = (cnt_q >= 16'd5);
`else
    assign len_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        ready     = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        unique case (state_q)
            StRun: begin
                ready = 1'b1;
                if (s.s_valid) begin
                    crc_d = (crc_q >> 8) ^ tab_rdata;
                    if (s.s_last) begin
                        state_d   = StReport;
                        crc_out_d = crc_d;
                    end
                end
            end
            StReport: begin
                done    = 1'b1;
                pass    = (crc_q == RESIDUE) && len_ok;
                state_d = StRun;
                crc_d   = INIT;
            end
            default: begin
                state_d = StRun;
                crc_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StRun;
            crc_q     <= INIT;
            crc_out_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
        end
    end

endmodule

// File: doc/crc_stream_check.md
CRC_STREAM_CHECK -- requirements
Module: crc_stream_check

Interface
REQ-001 SHALL have parameter INIT, default 32'hFFFFFFFF, CRC register preset at frame start.
REQ-002 SHALL have parameter RESIDUE, default 32'hDEBB20E3, expected CRC register value after a good frame including its appended FCS.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  byte valid.
REQ-006 SHALL have port s_ready  output  1  byte accepted when s_valid and s_ready both high.
REQ-007 SHALL have port s_data  input  8  frame byte, FCS bytes included, LSB-first reflected order.
REQ-008 SHALL have port s_last  input  1  marks final byte of frame.
REQ-009 SHALL have port tab_addr  output  32  lookup address to external 256-entry CRC table; bits [31:8] are zero.
REQ-010 SHALL have port tab_rdata  input  32  table word, combinational from tab_addr (same cycle).
REQ-011 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-012 SHALL have port pass  output  1  frame check result, valid when done=1, 0 otherwise.
REQ-013 SHALL have port crc_out  output  32  CRC register value of last completed frame.

Function
REQ-014 SHALL implement FSM with states RUN and REPORT.
REQ-015 SHALL hold CRC register crc; tab_addr SHALL be {24'h0, crc[7:0] ^ s_data} at all times.
REQ-016 SHALL, on each accepted byte, update crc <= (crc >> 8) ^ tab_rdata; one byte per cycle max, no extra latency.
REQ-017 SHALL drive s_ready=1 in RUN and s_ready=0 in REPORT.
REQ-018 SHALL leave crc unchanged in RUN cycles with s_valid=0 (gaps allowed anywhere in frame).
REQ-019 SHALL move RUN->REPORT on the edge accepting a byte with s_last=1.
REQ-020 SHALL in REPORT assert done=1 for exactly one cycle, pass=(crc==RESIDUE) and any enabled length check, then return to RUN with crc <= INIT.
REQ-021 SHALL update crc_out with the final crc on the RUN->REPORT edge and hold it until the next frame completes.
REQ-022 SHALL treat a single-byte frame (first byte has s_last=1) as a normal frame.
REQ-023 SHALL be table-content agnostic; polynomial defined solely by external table and RESIDUE.

Reset
REQ-024 SHALL on rstn low asynchronously set state=RUN, crc=INIT, crc_out=0, done=0, pass=0, byte count=0.
REQ-025 SHALL discard any partial frame when reset asserts mid-frame; no done pulse is generated for it.

Configuration
REQ-026 SHALL, with macro CRC_CHK_LEN_EN defined, count accepted bytes per frame in a 16-bit saturating counter (saturates at 16'hFFFF) and force pass=0 when count < 5 (runt: under 1 payload byte plus 4 FCS bytes); counter SHALL clear on REPORT->RUN.
REQ-027 SHALL, without CRC_CHK_LEN_EN, contain no byte counter and base pass solely on crc==RESIDUE.

Verification (standard reflected CRC-32 table, poly 0xEDB88320, default parameters)
REQ-028 SHALL test "123456789" + 26 39 F4 CB, contiguous -> done one cycle after last accept, pass=1, crc_out=32'hDEBB20E3.
REQ-029 SHALL test the same frame with bit 0 of byte '5' flipped -> done=1, pass=0.
REQ-030 SHALL test the same good frame with random s_valid gaps, followed back-to-back by a second good frame -> two done pulses, both pass=1, s_ready=0 only in REPORT cycles.
REQ-031 SHALL test "123456789" alone with s_last on '9' -> pass=0, crc_out=32'h340BC6D9.
REQ-032 SHALL test rstn pulsed low after 4 bytes, then the full good frame -> no done for the aborted frame, one done with pass=1.
REQ-033 SHALL test with CRC_CHK_LEN_EN defined a 4-byte frame 00 00 00 00 -> pass=0 regardless of CRC, and REQ-028 still passes.
